// File: rtl/cpu_control_sequencer_if.sv
// cpu_control_sequencer_if
//   Groups the sequencer's datapath/memory-facing signals.
//   master : the sequencer (drives control enables, the IR and status)
//   slave  : datapath / memory side (drives run, din, g_nz)
//   Signals:
//     run        start/continue request
//     din[15:0]  memory read data (1-cycle latency after addr_in)
//     g_nz       datapath G register is non-zero
//     ir[15:0]   instruction register
//     reg_in     one-hot register write enable R0-R7
//     reg_out    one-hot register-to-bus enable R0-R7
//     pc_out, din_out, g_out          bus source enables
//     a_in, g_in, add_sub             ALU controls
//     addr_in, dout_in, mem_wr        memory controls
//     pc_enable, pc_select            PC update (select 0 = +1, 1 = load bus)
//     done, halted                    status
interface cpu_control_sequencer_if;
    logic        run;
    logic [15:0] din;
    logic        g_nz;
    logic [15:0] ir;
    logic [7:0]  reg_in;
    logic [7:0]  reg_out;
    logic        pc_out;
    logic        din_out;
    logic        g_out;
    logic        a_in;
    logic        g_in;
    logic        add_sub;
    logic        addr_in;
    logic        dout_in;
    logic        mem_wr;
    logic        pc_enable;
    logic        pc_select;
    logic        done;
    logic        halted;

    modport master (
        input  run, din, g_nz,
        output ir, reg_in, reg_out, pc_out, din_out, g_out, a_in, g_in,
               add_sub, addr_in, dout_in, mem_wr, pc_enable, pc_select,
               done, halted
    );

    modport slave (
        output run, din, g_nz,
        input  ir, reg_in, reg_out, pc_out, din_out, g_out, a_in, g_in,
               add_sub, addr_in, dout_in, mem_wr, pc_enable, pc_select,
               done, halted
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer
//   Multi-cycle fetch/decode/execute controller for the 16-bit CPU.
//   Holds the instruction register and decodes all control enables
//   combinationally from state, IR and g_nz.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-low reset
//     bus  cpu_control_sequencer_if.master (see interface file)
//
//   state  | meaning
//   -------+-----------------------------------------------------
//   IDLE   | waiting for run, all outputs low
//   F0     | PC onto bus, load memory address
//   F1     | PC <= PC + 1
//   F2     | memory data valid, IR <= din
//   E1     | first execute cycle (single-cycle ops finish here)
//   E2     | second execute cycle (MVI/ADD/SUB/LD/ST)
//   E3     | last execute cycle of the six-cycle ops
//   HALT   | halted high, left only by reset
module cpu_control_sequencer (
    input logic                        clk,
    input logic                        rst,
    cpu_control_sequencer_if.master    bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_E1, S_E2, S_E3, S_HALT
    } state_t;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_MVNZ = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  opcode;
    logic [7:0]  rx_oh, ry_oh;

    logic [7:0]  reg_in, reg_out;
    logic        pc_out, din_out, g_out, a_in, g_in, add_sub;
    logic        addr_in, dout_in, mem_wr, pc_enable, pc_select;
    logic        done, halted, last;

    assign opcode = ir_q[15:12];
    assign rx_oh  = 8'b1 << ir_q[11:9];
    assign ry_oh  = 8'b1 << ir_q[8:6];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        reg_in    = 8'h00;
        reg_out   = 8'h00;
        pc_out    = 1'b0;
        din_out   = 1'b0;
        g_out     = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        add_sub   = 1'b0;
        addr_in   = 1'b0;
        dout_in   = 1'b0;
        mem_wr    = 1'b0;
        pc_enable = 1'b0;
        pc_select = 1'b0;
        done      = 1'b0;
        halted    = 1'b0;
        last      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_F0;
            end
            S_F0: begin
                pc_out  = 1'b1;
                addr_in = 1'b1;
                state_d = S_F1;
            end
            S_F1: begin
                pc_enable = 1'b1;
                state_d   = S_F2;
            end
            S_F2: begin
                ir_d    = bus.din;
                state_d = S_E1;
            end
            S_E1: begin
                state_d = S_E2;
                case (opcode)
                    OP_MV: begin
                        reg_out = ry_oh;
                        reg_in  = rx_oh;
                        last    = 1'b1;
                    end
                    OP_MVI: begin
                        pc_out  = 1'b1;
                        addr_in = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        reg_out = rx_oh;
                        a_in    = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        reg_out = ry_oh;
                        addr_in = 1'b1;
                    end
                    OP_MVNZ: begin
                        if (bus.g_nz) begin
                            reg_out = ry_oh;
                            reg_in  = rx_oh;
                        end
                        last = 1'b1;
                    end
                    OP_JMP: begin
                        reg_out   = ry_oh;
                        pc_enable = 1'b1;
                        pc_select = 1'b1;
                        last      = 1'b1;
                    end
                    OP_HALT: begin
                        done    = 1'b1;
                        state_d = S_HALT;
                    end
                    default: last = 1'b1;
                endcase
            end
            S_E2: begin
                state_d = S_E3;
                case (opcode)
                    OP_MVI: pc_enable = 1'b1;
                    OP_ADD, OP_SUB: begin
                        reg_out = ry_oh;
                        g_in    = 1'b1;
                        add_sub = opcode[0];
                    end
                    OP_ST: begin
                        reg_out = rx_oh;
                        dout_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E3: begin
                last = 1'b1;
                case (opcode)
                    OP_MVI, OP_LD: begin
                        din_out = 1'b1;
                        reg_in  = rx_oh;
                    end
                    OP_ADD, OP_SUB: begin
                        g_out  = 1'b1;
                        reg_in = rx_oh;
                    end
                    OP_ST: mem_wr = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // run is only looked at on an instruction's final cycle
        if (last) begin
            done    = 1'b1;
            state_d = bus.run ? S_F0 : S_IDLE;
        end
    end

    assign bus.ir        = ir_q;
    assign bus.reg_in    = reg_in;
    assign bus.reg_out   = reg_out;
    assign bus.pc_out    = pc_out;
    assign bus.din_out   = din_out;
    assign bus.g_out     = g_out;
    assign bus.a_in      = a_in;
    assign bus.g_in      = g_in;
    assign bus.add_sub   = add_sub;
    assign bus.addr_in   = addr_in;
    assign bus.dout_in   = dout_in;
    assign bus.mem_wr    = mem_wr;
    assign bus.pc_enable = pc_enable;
    assign bus.pc_select = pc_select;
    assign bus.done      = done;
    assign bus.halted    = halted;
endmodule

// File: tb/tb_cpu_control_sequencer.sv
module tb_cpu_control_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cpu_control_sequencer_if bus ();

    cpu_control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Packed view of all control outputs:
    // [28:21] reg_in [20:13] reg_out [12] pc_out [11] din_out [10] g_out
    // [9] a_in [8] g_in [7] add_sub [6] addr_in [5] dout_in [4] mem_wr
    // [3] pc_enable [2] pc_select [1] done [0] halted
    logic [28:0] outs;
    assign outs = {bus.reg_in, bus.reg_out, bus.pc_out, bus.din_out, bus.g_out,
                   bus.a_in, bus.g_in, bus.add_sub, bus.addr_in, bus.dout_in,
                   bus.mem_wr, bus.pc_enable, bus.pc_select, bus.done, bus.halted};

    localparam logic [28:0] PC_OUT  = 29'h1 << 12;
    localparam logic [28:0] DIN_OUT = 29'h1 << 11;
    localparam logic [28:0] G_OUT   = 29'h1 << 10;
    localparam logic [28:0] A_IN    = 29'h1 << 9;
    localparam logic [28:0] G_IN    = 29'h1 << 8;
    localparam logic [28:0] ADD_SUB = 29'h1 << 7;
    localparam logic [28:0] ADDR_IN = 29'h1 << 6;
    localparam logic [28:0] DOUT_IN = 29'h1 << 5;
    localparam logic [28:0] MEM_WR  = 29'h1 << 4;
    localparam logic [28:0] PC_EN   = 29'h1 << 3;
    localparam logic [28:0] PC_SEL  = 29'h1 << 2;
    localparam logic [28:0] DONE    = 29'h1 << 1;
    localparam logic [28:0] HALTED  = 29'h1;

    function automatic logic [28:0] ri(input int n);
        return 29'h1 << (21 + n);
    endfunction

    function automatic logic [28:0] ro(input int n);
        return 29'h1 << (13 + n);
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] instr;
        logic        gnz;
        logic [2:0]  ncyc;
        logic [1:0]  incs;
        logic [28:0] e1;
        logic [28:0] e2;
        logic [28:0] e3;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int   incs;

        // MV R2<-R5
        vecs[0]  = '{16'h0540, 1'b0, 3'd4, 2'd1, ro(5) | ri(2) | DONE, 29'h0, 29'h0};
        // MVI R1
        vecs[1]  = '{16'h1200, 1'b0, 3'd6, 2'd2, PC_OUT | ADDR_IN, PC_EN, DIN_OUT | ri(1) | DONE};
        // SUB R3,R4
        vecs[2]  = '{16'h3700, 1'b0, 3'd6, 2'd1, ro(3) | A_IN, ro(4) | G_IN | ADD_SUB, G_OUT | ri(3) | DONE};
        // ADD R5,R1
        vecs[3]  = '{16'h2A40, 1'b0, 3'd6, 2'd1, ro(5) | A_IN, ro(1) | G_IN, G_OUT | ri(5) | DONE};
        // LD R6,[R2]
        vecs[4]  = '{16'h4C80, 1'b0, 3'd6, 2'd1, ro(2) | ADDR_IN, 29'h0, DIN_OUT | ri(6) | DONE};
        // ST R7,[R0]
        vecs[5]  = '{16'h5E00, 1'b0, 3'd6, 2'd1, ro(0) | ADDR_IN, ro(7) | DOUT_IN, MEM_WR | DONE};
        // MVNZ R1,R1 with g_nz=0
        vecs[6]  = '{16'h6240, 1'b0, 3'd4, 2'd1, DONE, 29'h0, 29'h0};
        // MVNZ R1,R1 with g_nz=1
        vecs[7]  = '{16'h6240, 1'b1, 3'd4, 2'd1, ro(1) | ri(1) | DONE, 29'h0, 29'h0};
        // JMP R6
        vecs[8]  = '{16'h7180, 1'b0, 3'd4, 2'd1, ro(6) | PC_EN | PC_SEL | DONE, 29'h0, 29'h0};
        // NOP opcodes
        vecs[9]  = '{16'h9000, 1'b0, 3'd4, 2'd1, DONE, 29'h0, 29'h0};
        vecs[10] = '{16'hF123, 1'b1, 3'd4, 2'd1, DONE, 29'h0, 29'h0};
        // MV R0<-R0 (rx = ry)
        vecs[11] = '{16'h0000, 1'b0, 3'd4, 2'd1, ro(0) | ri(0) | DONE, 29'h0, 29'h0};

        rst      = 1'b0;
        bus.run  = 1'b0;
        bus.din  = 16'h0000;
        bus.g_nz = 1'b0;
        #3;
        chk("reset_outs", {3'b0, outs}, 32'h0);
        chk("reset_ir", {16'h0, bus.ir}, 32'h0);
        #9 rst = 1'b1;
        tick();
        chk("idle_after_reset", {3'b0, outs}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            v        = vecs[i];
            incs     = 0;
            bus.din  = v.instr;
            bus.g_nz = v.gnz;
            bus.run  = 1'b1;
            tick();
            bus.run = 1'b0;
            chk($sformatf("v%0d_F0", i), {3'b0, outs}, {3'b0, PC_OUT | ADDR_IN});
            tick();
            if (bus.pc_enable && !bus.pc_select) incs++;
            chk($sformatf("v%0d_F1", i), {3'b0, outs}, {3'b0, PC_EN});
            tick();
            chk($sformatf("v%0d_F2", i), {3'b0, outs}, 32'h0);
            tick();
            chk($sformatf("v%0d_ir", i), {16'h0, bus.ir}, {16'h0, v.instr});
            bus.din = 16'hDEAD;
            if (bus.pc_enable && !bus.pc_select) incs++;
            chk($sformatf("v%0d_E1", i), {3'b0, outs}, {3'b0, v.e1});
            if (v.ncyc == 3'd6) begin
                tick();
                if (bus.pc_enable && !bus.pc_select) incs++;
                chk($sformatf("v%0d_E2", i), {3'b0, outs}, {3'b0, v.e2});
                tick();
                if (bus.pc_enable && !bus.pc_select) incs++;
                chk($sformatf("v%0d_E3", i), {3'b0, outs}, {3'b0, v.e3});
            end
            tick();
            chk($sformatf("v%0d_idle", i), {3'b0, outs}, 32'h0);
            chk($sformatf("v%0d_pc_incs", i), incs, {30'h0, v.incs});
            chk($sformatf("v%0d_ir_hold", i), {16'h0, bus.ir}, {16'h0, v.instr});
            tick();
            chk($sformatf("v%0d_idle2", i), {3'b0, outs}, 32'h0);
        end

        // run held high: next fetch starts right after done
        bus.din  = 16'h0540;
        bus.g_nz = 1'b0;
        bus.run  = 1'b1;
        tick();
        chk("b2b_F0a", {3'b0, outs}, {3'b0, PC_OUT | ADDR_IN});
        tick();
        tick();
        tick();
        chk("b2b_E1a", {3'b0, outs}, {3'b0, ro(5) | ri(2) | DONE});
        tick();
        chk("b2b_F0b", {3'b0, outs}, {3'b0, PC_OUT | ADDR_IN});
        bus.run = 1'b0;
        tick();
        tick();
        tick();
        chk("b2b_E1b", {3'b0, outs}, {3'b0, ro(5) | ri(2) | DONE});
        tick();
        chk("b2b_idle", {3'b0, outs}, 32'h0);

        // reset in the middle of an ADD's E2
        bus.din = 16'h2A40;
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("rst_pre_E2", {3'b0, outs}, {3'b0, ro(1) | G_IN});
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_outs", {3'b0, outs}, 32'h0);
        chk("rst_mid_ir", {16'h0, bus.ir}, 32'h0);
        tick();
        chk("rst_held", {3'b0, outs}, 32'h0);
        #2 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rst_idle%0d", k), {3'b0, outs}, 32'h0);
        end

        // HALT: done pulse, then halted regardless of run
        bus.din = 16'h8000;
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        tick();
        tick();
        tick();
        chk("halt_E1", {3'b0, outs}, {3'b0, DONE});
        for (int k = 0; k < 20; k++) begin
            bus.run = k[0];
            tick();
            chk($sformatf("halted%0d", k), {3'b0, outs}, {3'b0, HALTED});
        end
        bus.run = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("halt_reset", {3'b0, outs}, 32'h0);
        #2 rst = 1'b1;
        tick();
        tick();
        chk("halt_reset_idle", {3'b0, outs}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Multi-cycle fetch/decode/execute controller for the 16-bit CPU. Sequences the program counter (increment and bus-load), holds the instruction register, and drives one-hot bus-source/destination enables, ALU controls and memory strobes for the register-file datapath. Sits between instruction memory/datapath and the existing program counter, which it drives through `pc_enable`/`pc_select`.

## Interface
- No parameters; data width fixed at 16, eight registers R0–R7.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `run` in 1: start/continue request; sampled only in IDLE and at instruction end.
- `din` in 16: memory read data (synchronous memory, 1-cycle read latency after `addr_in`).
- `g_nz` in 1: datapath G register is non-zero.
- `ir` out 16: instruction register.
- `reg_in` out 8: one-hot register write enable (R0–R7).
- `reg_out` out 8: one-hot register-to-bus enable.
- `pc_out`, `din_out`, `g_out` out 1 each: bus source enables.
- `a_in`, `g_in` out 1 each: ALU A / G register loads.
- `add_sub` out 1: 0 = add, 1 = subtract.
- `addr_in`, `dout_in`, `mem_wr` out 1 each: memory address load, write-data load, write strobe.
- `pc_enable`, `pc_select` out 1 each: PC update; `pc_select` 0 = PC+1, 1 = load bus.
- `done` out 1: one-cycle pulse on an instruction's last cycle.
- `halted` out 1: high while in HALT.

## Operation
- Instruction format: opcode `ir[15:12]`, rx `ir[11:9]`, ry `ir[8:6]`, `ir[5:0]` ignored.
- States: IDLE, F0, F1, F2, E1, E2, E3, HALT.
- IDLE: all outputs 0; `run`=1 → F0.
- F0: `pc_out`, `addr_in`. F1: `pc_enable` (`pc_select`=0). F2: IR ← `din`; → E1.
- Opcodes (E-states listed; last listed state asserts `done`):
  - 0 MV: E1 `reg_out[ry]`, `reg_in[rx]`.
  - 1 MVI (immediate = next word): E1 `pc_out`,`addr_in`; E2 `pc_enable`; E3 `din_out`,`reg_in[rx]`.
  - 2 ADD / 3 SUB: E1 `reg_out[rx]`,`a_in`; E2 `reg_out[ry]`,`g_in`, `add_sub`=opcode[0]; E3 `g_out`,`reg_in[rx]`.
  - 4 LD: E1 `reg_out[ry]`,`addr_in`; E2 wait; E3 `din_out`,`reg_in[rx]`.
  - 5 ST: E1 `reg_out[ry]`,`addr_in`; E2 `reg_out[rx]`,`dout_in`; E3 `mem_wr`.
  - 6 MVNZ: E1 if `g_nz` then `reg_out[ry]`,`reg_in[rx]`, else no enables.
  - 7 JMP: E1 `reg_out[ry]`, `pc_enable`, `pc_select`=1.
  - 8 HALT: E1 `done` → HALT.
  - 9–15: NOP, E1 `done` only.
- After `done`: `run`=1 → F0, else IDLE.
- HALT: `halted`=1, all other outputs 0; exits only by reset.
- Invariants: at most one bus source (`reg_out` bits, `pc_out`, `din_out`, `g_out`) high per cycle; `reg_in` at most one bit; `rx`=`ry` legal.

## Timing
- State register and IR update on rising `clk`; all control outputs decoded combinationally from state, IR and `g_nz`.
- Reset (`rst`=0, immediate): state IDLE, `ir`=0x0000, every output 0.
- Reset mid-instruction: aborts instantly, no partial strobes after reset edge.
- `run` dropping mid-instruction has no effect until `done`.
- Cycles per instruction incl. fetch: MV/MVNZ/JMP/NOP/HALT 4, MVI/ADD/SUB/LD/ST 6.
- `din` consumed exactly one cycle after its `addr_in` cycle's following edge (F2, MVI E3, LD E3).
- PC increments once per fetch, twice total for MVI; JMP replaces the increment from F1.

## Test plan
- Reset: `rst` low mid-E2 of ADD → all outputs 0, `ir`=0 immediately; release with `run`=0 → stays IDLE.
- MV R2←R5 (0x0540), `run`=1 → F0 `pc_out`+`addr_in`, F1 `pc_enable`/`pc_select`=0, E1 `reg_out`=0x20, `reg_in`=0x04, `done`; 4 cycles.
- MVI R1,#0x00FF (0x1200 then 0x00FF) → PC advances by 2; E3 `din_out`, `reg_in`=0x02, `done`; 6 cycles.
- SUB R3,R4 (0x3700) → E1 `reg_out`=0x08,`a_in`; E2 `reg_out`=0x10,`g_in`,`add_sub`=1; E3 `g_out`,`reg_in`=0x08.
- MVNZ with `g_nz`=0 → E1 all enables 0, `done`=1; JMP R6 (0x7180) → E1 `reg_out`=0x40, `pc_enable`=1, `pc_select`=1.
- HALT (0x8000) → `done` then `halted`=1 held for 20 cycles regardless of `run`; `run`=0 at any `done` → IDLE, no further fetch.
